// File: rtl/bg_pkg.sv
// Shared types and default constants for the bandgap lock monitor.
package bg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    STALL   = 2'd3
  } mon_state_t;

  localparam int DEF_WINDOW       = 16;
  localparam int DEF_LOCK_TOL     = 2;
  localparam int DEF_LOCK_WINDOWS = 4;
  localparam int DEF_UNLOCK_BAD   = 2;
  localparam int DEF_TIMEOUT      = 255;

endpackage

// File: rtl/bg_edge_event.sv
// Rise detection on the sequencer correction strobes and the idle timer.
// up/down are single-strobe rises; both flags a simultaneous rise. expire is
// high on the cycle whose edge brings the idle timer to TIMEOUT.
module bg_edge_event
  import bg_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic snk,
  input  logic src_n,
  output logic up,
  output logic down,
  output logic both,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          snk_prev;
  logic          src_prev;
  logic [TW-1:0] idle_cnt;
  logic          snk_rise;
  logic          src_rise;
  logic          any_rise;

  assign snk_rise = snk & ~snk_prev;
  assign src_rise = src_n & ~src_prev;
  assign any_rise = snk_rise | src_rise;
  assign up       = src_rise & ~snk_rise;
  assign down     = snk_rise & ~src_rise;
  assign both     = snk_rise & src_rise;
  // The timer sits at TIMEOUT-1 for exactly one cycle before saturating, so
  // expire can only fire once per quiet stretch.
  assign expire   = ~hold & ~any_rise & (idle_cnt == TW'(TIMEOUT - 1));

  // Previous strobe values and saturating idle timer (cleared by any rise).
  always_ff @(posedge clk) begin
    if (reset) begin
      snk_prev <= 1'b0;
      src_prev <= 1'b0;
      idle_cnt <= '0;
    end else begin
      snk_prev <= snk;
      src_prev <= src_n;
      if (hold || any_rise)
        idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT))
        idle_cnt <= idle_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/bg_lock_monitor.sv
// Integrates bandgap sequencer correction events over fixed windows and
// reports window balance, a hysteretic lock flag and a stall/restart request.
module bg_lock_monitor
  import bg_pkg::*;
#(
  parameter int WINDOW       = DEF_WINDOW,
  parameter int LOCK_TOL     = DEF_LOCK_TOL,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
  parameter int UNLOCK_BAD   = DEF_UNLOCK_BAD,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int BAL_W        = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    snk,
  input  logic                    src_n,
  input  logic                    setupBias,
  output logic signed [BAL_W-1:0] win_bal,
  output logic                    win_done,
  output logic                    locked,
  output logic                    stall,
  output logic                    restart_req,
  output logic                    err_both
);

  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);
  localparam logic signed [BAL_W-1:0] BAL_MAX = {1'b0, {(BAL_W-1){1'b1}}};
  localparam logic signed [BAL_W-1:0] BAL_MIN = -BAL_MAX;

  // Symmetric saturating +/-1 step of the balance accumulator.
  function automatic logic signed [BAL_W-1:0] sat_step(
    input logic signed [BAL_W-1:0] a, input logic inc);
    if (inc) return (a == BAL_MAX) ? a : a + BAL_W'(1);
    else     return (a == BAL_MIN) ? a : a - BAL_W'(1);
  endfunction

  // Good window test: |b| <= LOCK_TOL. b never reaches the most negative
  // code, so the magnitude always fits in BAL_W unsigned bits.
  function automatic logic is_good(input logic signed [BAL_W-1:0] b);
    logic [BAL_W-1:0] mag;
    mag = b[BAL_W-1] ? -b : b;
    return mag <= BAL_W'(LOCK_TOL);
  endfunction

  logic up, down, both, expire, ev;

  bg_edge_event #(.TIMEOUT(TIMEOUT)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .hold   (setupBias),
    .snk    (snk),
    .src_n  (src_n),
    .up     (up),
    .down   (down),
    .both   (both),
    .expire (expire)
  );

  assign ev = up | down;

  mon_state_t              state, state_n;
  logic signed [BAL_W-1:0] acc, acc_n, acc_t, win_bal_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [GOOD_W-1:0]       good, good_n;
  logic [BAD_W-1:0]        bad, bad_n;
  logic                    win_done_n, locked_n, stall_n, restart_n, err_n, good_win;

  // Next-state, window accumulation and flag logic.
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    acc_t      = acc;
    cnt_n      = cnt;
    good_n     = good;
    bad_n      = bad;
    win_bal_n  = win_bal;
    win_done_n = 1'b0;
    locked_n   = locked;
    stall_n    = stall;
    restart_n  = 1'b0;
    err_n      = err_both;
    good_win   = 1'b0;
    if (setupBias) begin
      state_n  = IDLE;
      acc_n    = '0;
      cnt_n    = '0;
      good_n   = '0;
      bad_n    = '0;
      locked_n = 1'b0;
      stall_n  = 1'b0;
    end else begin
      if (both) err_n = 1'b1;
      if (state == STALL) begin
        // Partial window frozen in STALL is discarded; the waking event opens a new one.
        if (ev) begin
          state_n = ACQUIRE;
          stall_n = 1'b0;
          acc_n   = sat_step('0, up);
          cnt_n   = CNT_W'(1);
          good_n  = '0;
        end
      end else begin
        if (state == IDLE) state_n = ACQUIRE;
        if (ev) begin
          acc_t = sat_step(acc, up);
          if (cnt == CNT_W'(WINDOW - 1)) begin
            win_bal_n  = acc_t;
            win_done_n = 1'b1;
            acc_n      = '0;
            cnt_n      = '0;
            good_win   = is_good(acc_t);
            if (good_win) begin
              bad_n  = '0;
              good_n = (good == GOOD_W'(LOCK_WINDOWS)) ? good : good + GOOD_W'(1);
            end else begin
              good_n = '0;
              bad_n  = (bad == BAD_W'(UNLOCK_BAD)) ? bad : bad + BAD_W'(1);
            end
            if (state != LOCKED && good_win && good_n == GOOD_W'(LOCK_WINDOWS)) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end else if (state == LOCKED && !good_win && bad_n == BAD_W'(UNLOCK_BAD)) begin
              state_n  = ACQUIRE;
              locked_n = 1'b0;
              good_n   = '0;
            end
          end else begin
            acc_n = acc_t;
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (expire && state != IDLE) begin
          state_n   = STALL;
          stall_n   = 1'b1;
          restart_n = 1'b1;
          locked_n  = 1'b0;
        end
      end
    end
  end

  // State, counters, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      good        <= '0;
      bad         <= '0;
      win_bal     <= '0;
      win_done    <= 1'b0;
      locked      <= 1'b0;
      stall       <= 1'b0;
      restart_req <= 1'b0;
      err_both    <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      good        <= good_n;
      bad         <= bad_n;
      win_bal     <= win_bal_n;
      win_done    <= win_done_n;
      locked      <= locked_n;
      stall       <= stall_n;
      restart_req <= restart_n;
      err_both    <= err_n;
    end
  end

endmodule

// File: tb/tb_bg_lock_monitor.sv
// Testbench for bg_lock_monitor: table vectors, directed corner sequences and
// randomized stimulus against a behavioural model.
module tb_bg_lock_monitor;
  import bg_pkg::*;

  localparam int WINDOW  = 16;
  localparam int TOL     = 2;
  localparam int LOCK_N  = 4;
  localparam int UNLK_N  = 2;
  localparam int TIMEOUT = 255;
  localparam int BAL_LIM = 31;

  logic clk = 1'b0;
  logic reset, snk, src_n, setupBias;
  logic signed [5:0] win_bal;
  logic win_done, locked, stall, restart_req, err_both;
  logic signed [3:0] s_win_bal;
  logic s_win_done, s_locked, s_stall, s_restart_req, s_err_both;

  always #5 clk = ~clk;

  bg_lock_monitor dut (
    .clk(clk), .reset(reset), .snk(snk), .src_n(src_n), .setupBias(setupBias),
    .win_bal(win_bal), .win_done(win_done), .locked(locked), .stall(stall),
    .restart_req(restart_req), .err_both(err_both)
  );

  bg_lock_monitor #(.BAL_W(4)) dut_s (
    .clk(clk), .reset(reset), .snk(snk), .src_n(src_n), .setupBias(setupBias),
    .win_bal(s_win_bal), .win_done(s_win_done), .locked(s_locked), .stall(s_stall),
    .restart_req(s_restart_req), .err_both(s_err_both)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int restart_cnt = 0;
  int last_bal = 0;
  int last_s_bal = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: plain integers, run lengths of good/bad windows.
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_STALL = 3;
  int mp_s, mp_u, m_mode, m_acc, m_cnt, m_good_run, m_bad_run, m_idle;
  int m_bal, m_done, m_locked, m_stall, m_restart, m_err;

  function automatic void model_step(input bit r, input bit sb, input bit s, input bit u);
    bit rs, ru, ev;
    int d, old_idle;
    if (r) begin
      mp_s = 0; mp_u = 0; m_mode = M_IDLE; m_acc = 0; m_cnt = 0; m_good_run = 0;
      m_bad_run = 0; m_idle = 0; m_bal = 0; m_done = 0; m_locked = 0; m_stall = 0;
      m_restart = 0; m_err = 0;
      return;
    end
    rs = s && (mp_s == 0);
    ru = u && (mp_u == 0);
    mp_s = s; mp_u = u;
    m_done = 0; m_restart = 0;
    if (sb) begin
      m_mode = M_IDLE; m_acc = 0; m_cnt = 0; m_good_run = 0; m_bad_run = 0;
      m_idle = 0; m_locked = 0; m_stall = 0;
      return;
    end
    if (rs && ru) m_err = 1;
    ev = (rs != ru);
    d = ru ? 1 : -1;
    old_idle = m_idle;
    m_idle = (rs || ru) ? 0 : ((m_idle < TIMEOUT) ? m_idle + 1 : TIMEOUT);
    if (m_mode == M_STALL) begin
      if (ev) begin
        m_mode = M_ACQ; m_stall = 0; m_acc = d; m_cnt = 1; m_good_run = 0;
      end
      return;
    end
    if (m_mode == M_IDLE) begin
      m_mode = M_ACQ;
      old_idle = 0;
    end
    if (ev) begin
      m_acc = m_acc + d;
      if (m_acc > BAL_LIM) m_acc = BAL_LIM;
      if (m_acc < -BAL_LIM) m_acc = -BAL_LIM;
      m_cnt++;
      if (m_cnt == WINDOW) begin
        m_bal = m_acc; m_done = 1; m_acc = 0; m_cnt = 0;
        if ((m_bal < 0 ? -m_bal : m_bal) <= TOL) begin
          m_good_run++; m_bad_run = 0;
        end else begin
          m_bad_run++; m_good_run = 0;
        end
        if (m_mode == M_ACQ && m_good_run >= LOCK_N) begin
          m_mode = M_LOCK; m_locked = 1;
        end else if (m_mode == M_LOCK && m_bad_run >= UNLK_N) begin
          m_mode = M_ACQ; m_locked = 0; m_good_run = 0;
        end
      end
    end else if (!(rs || ru) && old_idle == TIMEOUT - 1 && m_idle == TIMEOUT) begin
      m_mode = M_STALL; m_stall = 1; m_restart = 1; m_locked = 0;
    end
  endfunction

  // One clock: drive, advance model, sample 1ns after the edge, compare.
  task automatic cyc(input bit r, input bit sb, input bit s, input bit u);
    reset = r; setupBias = sb; snk = s; src_n = u;
    model_step(r, sb, s, u);
    @(posedge clk);
    #1;
    check("win_bal", int'(win_bal), m_bal);
    check("win_done", int'(win_done), m_done);
    check("locked", int'(locked), m_locked);
    check("stall", int'(stall), m_stall);
    check("restart_req", int'(restart_req), m_restart);
    check("err_both", int'(err_both), m_err);
    if (win_done) begin
      done_cnt++;
      last_bal = int'(win_bal);
      last_s_bal = int'(s_win_bal);
    end
    if (restart_req) restart_cnt++;
  endtask

  task automatic up_ev();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask

  task automatic dn_ev();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    bit r, sb, s, u;
    bit exp_done, exp_locked, exp_stall, exp_err;
  } vec_t;

  vec_t tbl[15];
  int d0, r0;

  initial begin
    // reset/idle with snk pulses, then a double rise
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 3; i < 13; i++) tbl[i] = '{0, 1, ((i % 2) == 1), 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 1, 1, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].sb, tbl[i].s, tbl[i].u);
      check("tbl_done", int'(win_done), int'(tbl[i].exp_done));
      check("tbl_locked", int'(locked), int'(tbl[i].exp_locked));
      check("tbl_stall", int'(stall), int'(tbl[i].exp_stall));
      check("tbl_err", int'(err_both), int'(tbl[i].exp_err));
      if (i == 12) begin
        check("idle_state", int'(dut.state), int'(IDLE));
        check("idle_bal", int'(win_bal), 0);
      end
    end

    // lock acquisition
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    d0 = done_cnt;
    for (int i = 0; i < 24; i++) begin up_ev(); dn_ev(); end
    check("acq_done3", done_cnt - d0, 3);
    check("acq_unlocked", int'(locked), 0);
    for (int i = 0; i < 8; i++) begin up_ev(); dn_ev(); end
    check("acq_done4", done_cnt - d0, 4);
    check("acq_bal", last_bal, 0);
    check("acq_locked", int'(locked), 1);

    // unlock hysteresis
    for (int i = 0; i < 16; i++) dn_ev();
    check("unl1_bal", last_bal, -16);
    check("unl1_sat_bal", last_s_bal, -7);
    check("unl1_locked", int'(locked), 1);
    for (int i = 0; i < 16; i++) dn_ev();
    check("unl2_locked", int'(locked), 0);
    for (int i = 0; i < 8; i++) begin up_ev(); dn_ev(); end
    check("unl3_bal", last_bal, 0);
    check("unl3_locked", int'(locked), 0);

    // saturation
    for (int i = 0; i < 16; i++) up_ev();
    check("sat_bal6", last_bal, 16);
    check("sat_bal4", last_s_bal, 7);

    // stall: one quiet cycle already elapsed inside up_ev
    r0 = restart_cnt;
    for (int i = 0; i < 253; i++) cyc(0, 0, 0, 0);
    check("stall_early", int'(stall), 0);
    cyc(0, 0, 0, 0);
    check("stall_set", int'(stall), 1);
    check("stall_restart", int'(restart_req), 1);
    check("stall_locked", int'(locked), 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    check("stall_one_pulse", restart_cnt - r0, 1);
    cyc(0, 0, 0, 1);
    check("wake_stall", int'(stall), 0);
    check("wake_state", int'(dut.state), int'(ACQUIRE));
    cyc(0, 0, 0, 0);
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) begin dn_ev(); up_ev(); end
    dn_ev();
    check("wake_window", done_cnt - d0, 1);

    // simultaneous rise
    d0 = last_bal;
    cyc(0, 0, 1, 1);
    check("both_err", int'(err_both), 1);
    check("both_bal", int'(win_bal), d0);
    cyc(0, 0, 0, 0);

    // setupBias abort mid-window
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) up_ev();
    cyc(0, 1, 0, 0);
    d0 = done_cnt;
    for (int i = 0; i < 15; i++) up_ev();
    check("abort_no_done", done_cnt - d0, 0);
    up_ev();
    check("abort_done", done_cnt - d0, 1);

    // randomized
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 900) == 0) begin
        for (int k = 0; k < 300; k++) cyc(0, 0, 0, 0);
      end else begin
        cyc(($urandom_range(0, 300) == 0), ($urandom_range(0, 80) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
